// File: rtl/serializer_if.sv
// Link bundle for the serializer: upstream word handshake, receiver pacing
// and the 1-bit data / write-strobe output.
interface serializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  ack_out;
    logic                  rx_ready_in;
    logic                  serial_out;
    logic                  write_out;
    logic                  busy_out;
    logic [7:0]            words_sent;

    modport master (
        output data_in, valid_in, rx_ready_in,
        input  ack_out, serial_out, write_out, busy_out, words_sent
    );

    modport slave (
        input  data_in, valid_in, rx_ready_in,
        output ack_out, serial_out, write_out, busy_out, words_sent
    );
endinterface

// File: rtl/serializer.sv
// Double-buffered parallel-to-serial transmitter: MSB-first bits, one per
// write_out strobe, paced by the receiver status with an idle gap between words.
module serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic clock_100KHZ,
    input  logic reset,
    serializer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam int unsigned GAP_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_full;
    logic                  hold_full_nxt;
    logic [DATA_WIDTH-1:0] shift;
    logic [CNT_W-1:0]      bit_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  capture;
    logic                  load;
    logic                  last_bit;

    // Handshake and transfer decisions for the coming edge
    always_comb begin
        capture       = bus.valid_in && !hold_full && !bus.ack_out;
        load          = hold_full && ((state == IDLE) ||
                        ((state == GAP) && (gap_cnt == GAP_W'(1))));
        last_bit      = (state == SHIFT) && bus.rx_ready_in &&
                        (bit_cnt == CNT_W'(DATA_WIDTH - 1));
        hold_full_nxt = (hold_full && !load) || capture;
        state_nxt     = state;
        case (state)
            IDLE:    if (hold_full) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = GAP;
            GAP:     if (gap_cnt == GAP_W'(1)) state_nxt = hold_full ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_100KHZ or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            hold           <= '0;
            hold_full      <= 1'b0;
            shift          <= '0;
            bit_cnt        <= '0;
            gap_cnt        <= '0;
            bus.ack_out    <= 1'b0;
            bus.serial_out <= 1'b0;
            bus.write_out  <= 1'b0;
            bus.busy_out   <= 1'b0;
            bus.words_sent <= '0;
        end else begin
            state        <= state_nxt;
            hold_full    <= hold_full_nxt;
            bus.busy_out <= hold_full_nxt || (state_nxt != IDLE);
            bus.ack_out  <= capture;
            bus.write_out <= 1'b0;
            if (capture) hold <= bus.data_in;
            if (load) begin
                shift   <= hold;
                bit_cnt <= '0;
            end
            case (state)
                SHIFT: begin
                    // A low rx_ready_in stalls with shift and count frozen
                    if (bus.rx_ready_in) begin
                        bus.serial_out <= shift[DATA_WIDTH-1];
                        bus.write_out  <= 1'b1;
                        shift          <= {shift[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt        <= bit_cnt + CNT_W'(1);
                        if (last_bit) begin
                            bit_cnt        <= '0;
                            gap_cnt        <= GAP_W'(GAP_CYCLES);
                            bus.words_sent <= bus.words_sent + 8'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(1)) gap_cnt <= '0;
                    else                      gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
